// File: rtl/lava_pkg.sv
// Shared types for the lava-lamp renderer: Q17.15 field values, the unit
// coordinate step and the pixel-scan controller state encoding.
package lava_pkg;

    typedef logic [31:0] fx_t;

    localparam fx_t FX_ONE  = 32'h0000_8000;
    localparam fx_t FX_STEP = FX_ONE;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        DONE
    } scan_state_t;

    // Clamp a field value to a 4-bit intensity.
    function automatic logic [3:0] sat4(input fx_t v);
        return (|v[31:4]) ? 4'hf : v[3:0];
    endfunction

endpackage

// File: rtl/field_sum.sv
// Registered saturating adder for N unsigned Q17.15 field values.
// The load enable lets the controller capture the balls only when all of
// them hold fresh results; the output then stays stable for the compare.
module field_sum
    import lava_pkg::*;
#(
    parameter int N = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [32*N-1:0] din,
    output fx_t            sum
);

    // One guard bit minimum so the overflow slice is never empty for N == 1.
    localparam int EXT   = (N > 1) ? $clog2(N) : 1;
    localparam int SUM_W = 32 + EXT;

    logic [SUM_W-1:0] term [N];
    logic [SUM_W-1:0] total;
    fx_t              sat;
    fx_t              sum_reg;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_term
            assign term[gi] = {{EXT{1'b0}}, din[32*gi +: 32]};
        end
    endgenerate

    // Wide unsigned sum, clamped to all-ones on any carry out of 32 bits.
    always_comb begin
        total = '0;
        for (int i = 0; i < N; i++) begin
            total = total + term[i];
        end
        sat = (|total[SUM_W-1:32]) ? 32'hffff_ffff : total[31:0];
    end

    // Capture the clamped sum when the controller samples the balls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg <= '0;
        end else if (en) begin
            sum_reg <= sat;
        end
    end

    assign sum = sum_reg;

endmodule

// File: rtl/metaball_scan_ctrl.sv
// Pixel-scan / compositing controller: walks every display pixel (y inner,
// x outer), strobes the metaball units, sums their fields, thresholds the
// sum and writes a colour into the top/bottom half buffers, then pulses
// swap at frame end. One extra frame request may queue while rendering.
module metaball_scan_ctrl
    import lava_pkg::*;
#(
    parameter int N_BALLS   = 3,
    parameter int W_PX      = 32,
    parameter int H_PX      = 64,
    parameter int ADDR_W    = 10,
    parameter int SHADE_LSB = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_go,
    input  logic                  mode,
    input  logic [31:0]           thresh,
    input  logic [N_BALLS-1:0]    mb_vld,
    input  logic [32*N_BALLS-1:0] mb_out,
    output logic                  px_stb,
    output logic [31:0]           p_x,
    output logic [31:0]           p_y,
    output logic [ADDR_W:0]       rom_addr,
    input  logic [11:0]           rom_dout,
    output logic                  w_en_top,
    output logic                  w_en_btm,
    output logic [ADDR_W-1:0]     w_addr,
    output logic [11:0]           din,
    output logic                  swap_en,
    output logic                  busy,
    output logic                  frame_miss
);

    localparam int IDX_W = ADDR_W + 1;
    localparam int X_W   = (W_PX > 1) ? $clog2(W_PX) : 1;
    localparam int Y_W   = (H_PX > 1) ? $clog2(H_PX) : 1;
    localparam logic [X_W-1:0] X_LAST = X_W'(W_PX - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(H_PX - 1);

    scan_state_t      state_reg, state_next;
    logic [X_W-1:0]   x_reg;
    logic [Y_W-1:0]   y_reg;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] rom_addr_reg;
    logic             pending_reg, miss_reg, busy_reg, mode_reg, skip_reg;
    fx_t              thresh_reg;
    fx_t              sum;
    logic             start, sample_en, last_px, pass;
    logic [3:0]       shade_q;
    logic [11:0]      colour;

    assign start     = (state_reg == IDLE) && (frame_go || pending_reg);
    // The vld levels of the previous pixel drop one cycle after the strobe,
    // so the first WAIT cycle is never trusted.
    assign sample_en = (state_reg == WAIT) && !skip_reg && (&mb_vld);
    assign last_px   = (x_reg == X_LAST) && (y_reg == Y_LAST);
    assign idx       = IDX_W'(int'(x_reg) * H_PX + int'(y_reg));

    field_sum #(.N(N_BALLS)) u_sum (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (sample_en),
        .din   (mb_out),
        .sum   (sum)
    );

    // Threshold and colour selection from the registered sum.
    always_comb begin
        pass    = (sum >= thresh_reg);
        shade_q = sat4(sum >> SHADE_LSB);
        colour  = 12'h000;
        if (pass) begin
            colour = mode_reg ? {shade_q, shade_q, shade_q} : rom_dout;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_next = state_reg;
        px_stb     = 1'b0;
        w_en_top   = 1'b0;
        w_en_btm   = 1'b0;
        din        = 12'h000;
        swap_en    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = ISSUE;
            end
            ISSUE: begin
                px_stb     = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (sample_en) state_next = WRITE;
            end
            WRITE: begin
                w_en_top   = !idx[ADDR_W];
                w_en_btm   = idx[ADDR_W];
                din        = colour;
                state_next = last_px ? DONE : ISSUE;
            end
            DONE: begin
                swap_en    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Coordinate counters, ROM address and the stale-vld skip flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg        <= '0;
            y_reg        <= '0;
            rom_addr_reg <= '0;
            skip_reg     <= 1'b0;
        end else begin
            if (state_reg == ISSUE) begin
                rom_addr_reg <= idx;
                skip_reg     <= 1'b1;
            end
            if (state_reg == WAIT) begin
                skip_reg <= 1'b0;
            end
            if (state_reg == WRITE) begin
                if (y_reg == Y_LAST) begin
                    y_reg <= '0;
                    x_reg <= (x_reg == X_LAST) ? '0 : x_reg + 1'b1;
                end else begin
                    y_reg <= y_reg + 1'b1;
                end
            end
        end
    end

    // Frame start bookkeeping: busy, sampled mode/threshold, pending and miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg    <= 1'b0;
            mode_reg    <= 1'b0;
            thresh_reg  <= '0;
            pending_reg <= 1'b0;
            miss_reg    <= 1'b0;
        end else begin
            if (state_reg == IDLE) begin
                if (frame_go && pending_reg) miss_reg <= 1'b1;
                if (start) begin
                    busy_reg    <= 1'b1;
                    mode_reg    <= mode;
                    thresh_reg  <= thresh;
                    pending_reg <= 1'b0;
                end
            end else if (frame_go) begin
                if (pending_reg) begin
                    miss_reg <= 1'b1;
                end else begin
                    pending_reg <= 1'b1;
                end
            end
            if (state_reg == DONE) begin
                busy_reg <= 1'b0;
            end
        end
    end

    assign p_x        = fx_t'(x_reg) * FX_STEP;
    assign p_y        = fx_t'(y_reg) * FX_STEP;
    assign rom_addr   = rom_addr_reg;
    assign w_addr     = idx[ADDR_W-1:0];
    assign busy       = busy_reg;
    assign frame_miss = miss_reg;

endmodule

// File: tb/tb_metaball_scan_ctrl.sv
// Bench for metaball_scan_ctrl: behavioural metaball/ROM responders and a
// pixel-order reference model (the k-th strobe of a frame is pixel k).
module tb_metaball_scan_ctrl;

    localparam int N    = 3;
    localparam int W    = 32;
    localparam int H    = 64;
    localparam int AW   = 10;
    localparam int NPIX = W * H;
    localparam int HALF = 1 << AW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            frame_go;
    logic            mode;
    logic [31:0]     thresh;
    logic [N-1:0]    mb_vld;
    logic [32*N-1:0] mb_out;
    logic            px_stb;
    logic [31:0]     p_x, p_y;
    logic [AW:0]     rom_addr;
    logic [11:0]     rom_dout;
    logic            w_en_top, w_en_btm;
    logic [AW-1:0]   w_addr;
    logic [11:0]     din;
    logic            swap_en, busy, frame_miss;

    metaball_scan_ctrl #(
        .N_BALLS(N), .W_PX(W), .H_PX(H), .ADDR_W(AW), .SHADE_LSB(13)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_go(frame_go), .mode(mode),
        .thresh(thresh), .mb_vld(mb_vld), .mb_out(mb_out), .px_stb(px_stb),
        .p_x(p_x), .p_y(p_y), .rom_addr(rom_addr), .rom_dout(rom_dout),
        .w_en_top(w_en_top), .w_en_btm(w_en_btm), .w_addr(w_addr),
        .din(din), .swap_en(swap_en), .busy(busy), .frame_miss(frame_miss)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          pix_k, writes_k, outstanding, exp_k, cur_frame, started, swaps;
    int          skew_max, swaps_before;
    bit          swap_seen;
    logic [11:0] exp_din;
    int          phase [N];
    int          cnt [N];
    logic [31:0] nextv [N];
    int          fmode [4];
    logic [31:0] fthr [4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] rom_fn(input int a);
        return 12'((a * 37 + 11) % 4096);
    endfunction

    // Reference colour for pixel k from the ball values drawn for it.
    function automatic logic [11:0] model_din(input int md, input logic [31:0] th, input int k);
        longint unsigned tot = 0;
        longint unsigned q;
        for (int i = 0; i < N; i++) tot += 64'(nextv[i]);
        if (tot > 64'hffff_ffff) tot = 64'hffff_ffff;
        if (tot < 64'(th)) return 12'h000;
        if (md == 0) return rom_fn(k);
        q = tot / 8192;
        if (q > 15) q = 15;
        return 12'(q * 64'h111);
    endfunction

    task automatic pick_values();
        logic [31:0] v [N];
        int sc = $urandom_range(0, 7);
        int r  = $urandom_range(0, N - 1);
        for (int i = 0; i < N; i++) v[i] = 32'h0;
        case (sc)
            0: v[0] = 32'h0000_8000;
            1: for (int i = 0; i < N; i++) v[i] = 32'hffff_0000;
            2: v[0] = 32'h0000_7fff;
            3: for (int i = 0; i < N; i++) v[i] = 32'h0000_2000;
            4: v[0] = 32'h0010_0000;
            5: for (int i = 0; i < N; i++) v[i] = $urandom;
            6: begin v[0] = 32'hffff_ffff; v[1] = 32'h1; end
            default: begin v[0] = 32'hffff_fffe; v[1] = 32'h1; end
        endcase
        for (int i = 0; i < N; i++) nextv[(i + r) % N] = v[i];
    endtask

    // One clock: observe outputs at the falling edge, then drive responders.
    task automatic step();
        @(negedge clk);
        if (w_en_top || w_en_btm) begin
            check("write_expected", 64'(outstanding), 64'd1);
            check("w_en_top", 64'(w_en_top), 64'(exp_k < HALF));
            check("w_en_btm", 64'(w_en_btm), 64'(exp_k >= HALF));
            check("w_addr", 64'(w_addr), 64'(exp_k % HALF));
            check("din", 64'(din), 64'(exp_din));
            outstanding = 0;
            writes_k++;
        end
        if (swap_en) begin
            check("swap_writes", 64'(writes_k), 64'(NPIX));
            check("swap_idle_px", 64'(outstanding), 64'd0);
            $display("frame %0d swap after %0d writes", cur_frame, writes_k);
            swaps++;
            swap_seen = 1'b1;
            pix_k     = 0;
            writes_k  = 0;
        end
        for (int i = 0; i < N; i++) begin
            case (phase[i])
                1: phase[i] = 2;
                2: begin mb_vld[i] = 1'b0; cnt[i] = $urandom_range(0, skew_max); phase[i] = 3; end
                3: begin
                    if (cnt[i] == 0) begin
                        mb_vld[i] = 1'b1;
                        mb_out[32*i +: 32] = nextv[i];
                        phase[i] = 0;
                    end else begin
                        cnt[i]--;
                    end
                end
                default: ;
            endcase
        end
        if (px_stb) begin
            check("px_stb_once", 64'(outstanding), 64'd0);
            if (pix_k == 0) begin
                cur_frame = started;
                started++;
            end
            check("p_x", 64'(p_x), 64'((pix_k / H) * 32768));
            check("p_y", 64'(p_y), 64'((pix_k % H) * 32768));
            pick_values();
            exp_din     = model_din(fmode[cur_frame], fthr[cur_frame], pix_k);
            exp_k       = pix_k;
            pix_k++;
            outstanding = 1;
            for (int i = 0; i < N; i++) phase[i] = 1;
        end
        rom_dout = rom_fn(int'(rom_addr));
    endtask

    task automatic run_until_swap(input int budget, input string tag);
        int n = 0;
        swap_seen = 1'b0;
        while (!swap_seen && n < budget) begin
            step();
            n++;
        end
        check({tag, "_swap_seen"}, 64'(swap_seen), 64'd1);
    endtask

    task automatic run_until_pix(input int target, input int budget);
        int n = 0;
        while (pix_k < target && n < budget) begin
            step();
            n++;
        end
        check("reach_pixel", 64'(pix_k >= target), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_px_stb"}, 64'(px_stb), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_swap_en"}, 64'(swap_en), 64'd0);
        check({tag, "_w_en_top"}, 64'(w_en_top), 64'd0);
        check({tag, "_w_en_btm"}, 64'(w_en_btm), 64'd0);
        check({tag, "_p_x"}, 64'(p_x), 64'd0);
        check({tag, "_p_y"}, 64'(p_y), 64'd0);
        check({tag, "_rom_addr"}, 64'(rom_addr), 64'd0);
        check({tag, "_w_addr"}, 64'(w_addr), 64'd0);
        check({tag, "_din"}, 64'(din), 64'd0);
        check({tag, "_frame_miss"}, 64'(frame_miss), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; frame_go = 1'b0; mode = 1'b0; thresh = 32'h0;
        mb_vld = '1; mb_out = {$urandom, $urandom, $urandom}; rom_dout = 12'h0;
        pix_k = 0; writes_k = 0; outstanding = 0; exp_k = 0; cur_frame = 0;
        started = 0; swaps = 0; skew_max = 5; swap_seen = 1'b0; exp_din = 12'h0;
        for (int i = 0; i < N; i++) begin phase[i] = 0; cnt[i] = 0; nextv[i] = 32'h0; end
        fmode[0] = 0; fthr[0] = 32'h0000_8000;
        fmode[1] = 1; fthr[1] = 32'h0000_6000;
        fmode[2] = 0; fthr[2] = 32'hffff_ffff;
        fmode[3] = 1; fthr[3] = 32'hffff_ffff;

        repeat (3) step();
        check_all_zero("reset");
        $display("step reset: outputs checked");
        rst_n = 1'b1;
        repeat (3) step();
        check("idle_busy", 64'(busy), 64'd0);

        // Frame 0: mode 0, skewed out-of-order balls, two extra requests.
        mode = 1'b0; thresh = fthr[0]; frame_go = 1'b1;
        step();
        frame_go = 1'b0;
        mode = 1'b1; thresh = fthr[1];
        check("f0_busy", 64'(busy), 64'd1);
        run_until_pix(100, 5000);
        frame_go = 1'b1; step(); frame_go = 1'b0;
        check("miss_after_2nd", 64'(frame_miss), 64'd0);
        $display("step f0: second frame_go queued");
        run_until_pix(200, 5000);
        frame_go = 1'b1; step(); frame_go = 1'b0;
        check("miss_after_3rd", 64'(frame_miss), 64'd1);
        $display("step f0: third frame_go dropped");
        run_until_swap(30000, "f0");

        // Frame 1 starts from the queued request without a new frame_go.
        for (int i = 0; i < 4 && pix_k == 0; i++) step();
        check("f1_prompt_start", 64'(pix_k), 64'd1);
        mode = 1'b0; thresh = fthr[2]; skew_max = 2;
        run_until_swap(30000, "f1");
        // Request in the DONE cycle queues the next frame.
        frame_go = 1'b1; step(); frame_go = 1'b0;
        check("miss_sticky", 64'(frame_miss), 64'd1);

        // Frame 2: abandoned by reset around pixel 700.
        run_until_pix(700, 20000);
        step(); step();
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        $display("step f2: reset at pixel %0d", pix_k);
        pix_k = 0; writes_k = 0; outstanding = 0;
        for (int i = 0; i < N; i++) phase[i] = 0;
        mb_vld = '1;
        swaps_before = swaps;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (40) step();
        check("no_swap_after_rst", 64'(swaps), 64'(swaps_before));
        check("idle_after_rst", 64'(busy), 64'd0);

        // Frame 3: restart from (0,0), shaded mode at the maximum threshold.
        mode = 1'b1; thresh = fthr[3]; frame_go = 1'b1;
        step();
        frame_go = 1'b0;
        check("f3_busy", 64'(busy), 64'd1);
        check("f3_first_pixel", 64'(pix_k), 64'd1);
        run_until_swap(30000, "f3");
        check("swap_total", 64'(swaps), 64'd3);
        check("miss_cleared", 64'(frame_miss), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
